// File: rtl/data_bus_arbiter_pkg.sv
// data_bus_arbiter_pkg: shared types and defaults for the two-master data bus arbiter
package data_bus_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
    localparam int READ_LAT_DEF = 1;
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  be;
    } cmd_t;
endpackage

// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: master request/ack signals plus the Dw memory-side bus
interface data_bus_arbiter_if;
    logic        iReq0, iReq1, iWe0, iWe1;
    logic [63:0] iAddr0, iAddr1, iWData0, iWData1;
    logic [3:0]  iBE0, iBE1;
    logic        oAck0, oAck1, oStall0, oBusy, oOwner;
    logic [63:0] oRData0, oRData1;
    logic        DwReadEnable, DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [63:0] DwAddress, DwWriteData, DwReadData;
    modport slave (
        input  iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iBE0, iBE1, DwReadData,
        output oAck0, oAck1, oStall0, oBusy, oOwner, oRData0, oRData1,
               DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData
    );
    modport master (
        output iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iBE0, iBE1, DwReadData,
        input  oAck0, oAck1, oStall0, oBusy, oOwner, oRData0, oRData1,
               DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData
    );
endinterface

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin picker; the master not granted last wins a tie
module rr_arbiter2 (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [1:0] req,
    input  logic       en,
    output logic       win
);
    logic pri;
    assign win = req[pri] ? pri : ~pri;
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            pri <= 1'b0;
        else if (en)
            pri <= ~win;
    end
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares the 64-bit Dw data bus between the CPU (master 0) and a DMA (master 1)
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEF
) (
    input logic               iCLK,
    input logic               iRST,
    data_bus_arbiter_if.slave bus
);
    state_t      state;
    cmd_t        cmd;
    cmd_t        sel;
    logic [2:0]  cnt;
    logic [1:0]  req;
    logic        win;
    logic        grant;
    assign req = {bus.iReq1, bus.iReq0};
    assign grant = (state == ST_IDLE || state == ST_RESP) && |req;
    assign sel = win ? {bus.iWe1, bus.iAddr1, bus.iWData1, bus.iBE1}
                     : {bus.iWe0, bus.iAddr0, bus.iWData0, bus.iBE0};
    assign bus.DwAddress = cmd.addr;
    assign bus.DwWriteData = cmd.wdata;
    assign bus.oStall0 = bus.iReq0 & ~bus.oAck0;
    assign bus.oBusy = state != ST_IDLE;
    rr_arbiter2 u_rr (
        .iCLK(iCLK),
        .iRST(iRST),
        .req (req),
        .en  (grant),
        .win (win)
    );
    // Strobes and acks are single-cycle pulses: cleared every cycle unless the state sets them
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= ST_IDLE;
            cmd <= '0;
            cnt <= '0;
            bus.oAck0 <= 1'b0;
            bus.oAck1 <= 1'b0;
            bus.oOwner <= 1'b0;
            bus.oRData0 <= '0;
            bus.oRData1 <= '0;
            bus.DwReadEnable <= 1'b0;
            bus.DwWriteEnable <= 1'b0;
            bus.DwByteEnable <= '0;
        end else begin
            bus.oAck0 <= 1'b0;
            bus.oAck1 <= 1'b0;
            bus.DwReadEnable <= 1'b0;
            bus.DwWriteEnable <= 1'b0;
            bus.DwByteEnable <= '0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (grant) begin
                        state <= ST_ACCESS;
                        cmd <= sel;
                        bus.oOwner <= win;
                        bus.DwWriteEnable <= sel.we;
                        bus.DwReadEnable <= ~sel.we;
                        bus.DwByteEnable <= sel.be;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state <= cmd.we ? ST_RESP : ST_WAIT;
                    cnt <= 3'(READ_LAT);
                    bus.oAck0 <= cmd.we & ~bus.oOwner;
                    bus.oAck1 <= cmd.we & bus.oOwner;
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ST_RESP;
                        bus.oAck0 <= ~bus.oOwner;
                        bus.oAck1 <= bus.oOwner;
                        if (bus.oOwner)
                            bus.oRData1 <= bus.DwReadData;
                        else
                            bus.oRData0 <= bus.DwReadData;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
